// File: rtl/pong_vga_scan.sv
// pong_vga_scan
//   VGA scan-out stage for the pong ball datapath. Derives a 25 MHz pixel
//   step from the 50 MHz clock and generates 640x480@60 Hz timing. It paints
//   a BALL_SIZE square at the ball position, which is latched once per frame
//   at the start of vertical blank. A one-clk frame_tick is emitted at that
//   latch point so upstream stages can step the ball once per frame.
//
//   Optional feature macro: PONG_BORDER_EN
//     defined   -> 5-pixel wall in BALL_RGB around the visible region
//                  (ball > wall > background priority)
//     undefined -> ball or background only
//
// Ports
//   clk        50 MHz system clock
//   rst        asynchronous active-low reset
//   ballx      ball top-left x in pixels (12 bits)
//   bally      ball top-left y in pixels (12 bits)
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   video_on   high inside the visible region
//   red/green/blue  4-bit pixel colour, 0 outside the visible region
//   frame_tick one-clk pulse per frame, coincident with the position latch
//
// The raster geometry parameters default to standard 640x480@60 timing.
// Non-default values scale the raster only; all outputs keep the same
// relative behaviour.

module pong_vga_scan #(
  parameter int unsigned BALL_SIZE = 20,
  parameter logic [11:0] BALL_RGB  = 12'hFFF,
  parameter logic [11:0] BG_RGB    = 12'h000,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ballx,
  input  logic [11:0] bally,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
  localparam logic [11:0] HS_FIRST   = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_LAST    = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST   = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_LAST    = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [12:0] BALL_EXTENT = 13'(BALL_SIZE);

`ifdef PONG_BORDER_EN
  localparam logic [11:0] WALL_W     = 12'd5;
  localparam logic [11:0] WALL_RIGHT = 12'(H_VISIBLE - 6);
  localparam logic [11:0] WALL_BOT   = 12'(V_VISIBLE - 6);
`endif

  logic        phase;
  logic        pix_en;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [11:0] bx;
  logic [11:0] by;

  logic        visible;
  logic        in_hsync;
  logic        in_vsync;
  logic        latch_pt;
  logic        hit;
  logic [12:0] bx_end;
  logic [12:0] by_end;
  logic [11:0] pix_rgb;
`ifdef PONG_BORDER_EN
  logic        wall;
`endif

  assign pix_en = phase;

  // Decode from pre-advance counters; results are registered on pix_en so
  // every output lags the counters by exactly one pixel step.
  always_comb begin
    visible  = (hcnt < H_VIS) && (vcnt < V_VIS);
    in_hsync = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    in_vsync = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    latch_pt = (hcnt == '0) && (vcnt == V_VIS);

    // 13-bit sums keep positions near 4095 from wrapping back onto the screen.
    bx_end = {1'b0, bx} + BALL_EXTENT;
    by_end = {1'b0, by} + BALL_EXTENT;
    hit    = (hcnt >= bx) && ({1'b0, hcnt} < bx_end) &&
             (vcnt >= by) && ({1'b0, vcnt} < by_end);

`ifdef PONG_BORDER_EN
    wall = (hcnt < WALL_W) || (hcnt > WALL_RIGHT) ||
           (vcnt < WALL_W) || (vcnt > WALL_BOT);
`endif

    pix_rgb = '0;
    if (visible) begin
      if (hit) begin
        pix_rgb = BALL_RGB;
`ifdef PONG_BORDER_EN
      end else if (wall) begin
        pix_rgb = BALL_RGB;
`endif
      end else begin
        pix_rgb = BG_RGB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      bx         <= '0;
      by         <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      frame_tick <= 1'b0;
    end else begin
      phase <= ~phase;
      // Next clk edge is never a pixel step, so this self-clears after 1 clk.
      frame_tick <= pix_en && latch_pt;

      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 12'd1;
        end else begin
          hcnt <= hcnt + 12'd1;
        end

        if (latch_pt) begin
          bx <= ballx;
          by <= bally;
        end

        hsync              <= ~in_hsync;
        vsync              <= ~in_vsync;
        video_on           <= visible;
        {red, green, blue} <= pix_rgb;
      end
    end
  end

endmodule

// File: tb/tb_pong_vga_scan.sv
// tb_pong_vga_scan
//   Two instances share clock, reset and ball inputs: one at standard
//   640x480 geometry and one with a shrunken raster so that several whole
//   frames fit in a short run. A flat raster-index model predicts every
//   pixel of both instances; predictions are queued on each pixel step and
//   compared at the following falling clock edge.

module tb_pong_vga_scan;

  // shrunken raster
  localparam int HVS = 40, HFS = 4, HSS = 6, HBS = 6;
  localparam int VVS = 30, VFS = 2, VSS = 2, VBS = 4;
  localparam int HTS = HVS + HFS + HSS + HBS;
  localparam int VTS = VVS + VFS + VSS + VBS;
  localparam int FS  = HTS * VTS;
  localparam int BSS = 4;
  localparam logic [11:0] BCS = 12'hA5C;
  localparam logic [11:0] GCS = 12'h123;

  // standard raster
  localparam int HTF = 800, VTF = 525;

  localparam logic [15:0] RST_VEC = 16'hC000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] ballx = '0;
  logic [11:0] bally = '0;

  logic       hsync_s, vsync_s, video_on_s, frame_tick_s;
  logic [3:0] red_s, green_s, blue_s;
  logic       hsync_f, vsync_f, video_on_f, frame_tick_f;
  logic [3:0] red_f, green_f, blue_f;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] s;
    logic [15:0] f;
  } exp_t;
  exp_t sb[$];

  int ph  = 0;
  int g   = 0;
  int sbx = 0, sby = 0, fbx = 0, fby = 0;

  always #10 clk = ~clk;

  pong_vga_scan #(
    .BALL_SIZE(BSS), .BALL_RGB(BCS), .BG_RGB(GCS),
    .H_VISIBLE(HVS), .H_FRONT(HFS), .H_SYNC(HSS), .H_BACK(HBS),
    .V_VISIBLE(VVS), .V_FRONT(VFS), .V_SYNC(VSS), .V_BACK(VBS)
  ) dut_s (
    .clk(clk), .rst(rst), .ballx(ballx), .bally(bally),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
    .red(red_s), .green(green_s), .blue(blue_s), .frame_tick(frame_tick_s)
  );

  pong_vga_scan dut_f (
    .clk(clk), .rst(rst), .ballx(ballx), .bally(bally),
    .hsync(hsync_f), .vsync(vsync_f), .video_on(video_on_f),
    .red(red_f), .green(green_f), .blue(blue_f), .frame_tick(frame_tick_f)
  );

  wire [15:0] act_s = {hsync_s, vsync_s, video_on_s, red_s, green_s, blue_s, frame_tick_s};
  wire [15:0] act_f = {hsync_f, vsync_f, video_on_f, red_f, green_f, blue_f, frame_tick_f};

  // {hsync, vsync, video_on, rgb[11:0], frame_tick} for raster index gi
  function automatic logic [15:0] exp_out(input int gi, input int ht, input int vt,
                                          input int hv, input int hf, input int hsw,
                                          input int vv, input int vf, input int vsw,
                                          input int bs, input logic [11:0] bc,
                                          input logic [11:0] gc, input int bx, input int by);
    int r, x, y;
    logic hs, vs, von, hit, wall, ft;
    logic [11:0] c;
    r    = gi % (ht * vt);
    x    = r % ht;
    y    = r / ht;
    hs   = !(x >= hv + hf && x < hv + hf + hsw);
    vs   = !(y >= vv + vf && y < vv + vf + vsw);
    von  = (x < hv) && (y < vv);
    hit  = (x >= bx) && (x < bx + bs) && (y >= by) && (y < by + bs);
    wall = 1'b0;
`ifdef PONG_BORDER_EN
    wall = (x < 5) || (x > hv - 6) || (y < 5) || (y > vv - 6);
`endif
    c  = !von ? 12'h000 : hit ? bc : wall ? bc : gc;
    ft = (x == 0) && (y == vv);
    return {hs, vs, von, c, ft};
  endfunction

  function automatic bit is_latch(input int gi, input int ht, input int vt, input int vv);
    int r;
    r = gi % (ht * vt);
    return (r == vv * ht);
  endfunction

  task automatic chk(input string tag, input logic [15:0] a, input logic [15:0] e);
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (pix=%0d)", tag, a, e, g);
    end
  endtask

  // reference model: one prediction per pixel step
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = 0; g = 0;
      sbx = 0; sby = 0; fbx = 0; fby = 0;
      sb.delete();
    end else begin
      if (ph == 1) begin
        exp_t e;
        e.s = exp_out(g, HTS, VTS, HVS, HFS, HSS, VVS, VFS, VSS, BSS, BCS, GCS, sbx, sby);
        e.f = exp_out(g, HTF, VTF, 640, 16, 96, 480, 10, 2, 20, 12'hFFF, 12'h000, fbx, fby);
        sb.push_back(e);
        if (is_latch(g, HTS, VTS, VVS)) begin sbx = int'(ballx); sby = int'(bally); end
        if (is_latch(g, HTF, VTF, 480))  begin fbx = int'(ballx); fby = int'(bally); end
        g++;
      end
      ph = 1 - ph;
    end
  end

  // checker
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_s", act_s, RST_VEC);
      chk("reset_f", act_f, RST_VEC);
    end else if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pixel_s", act_s, e.s);
      chk("pixel_f", act_f, e.f);
    end else if (g == 0) begin
      chk("prestep_s", act_s, RST_VEC);
      chk("prestep_f", act_f, RST_VEC);
    end else begin
      chk("tick_width_s", {15'd0, frame_tick_s}, 16'd0);
      chk("tick_width_f", {15'd0, frame_tick_f}, 16'd0);
    end
  end

  task automatic wait_row(input int row);
    int budget;
    budget = 2 * FS * 2 + 10;
    while (((g % FS) / HTS) != row && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $error("FAIL wait_row: observed=timeout expected=row %0d", row);
    end
  endtask

  initial begin
    rst   = 1'b0;
    ballx = 12'd10;
    bally = 12'd8;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // run into a line, then reset asynchronously mid-line
    repeat (900) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_s", act_s, RST_VEC);
    chk("async_rst_f", act_f, RST_VEC);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // ball at reset position in frame 0, at (10,8) from frame 1
    repeat (2 * FS * 2 + 40) @(negedge clk);

    // move x mid-frame; current frame keeps the old column
    wait_row(15);
    ballx = 12'd25;
    repeat (2 * FS * 2 + 40) @(negedge clk);

    // partly off the bottom-right corner
    ballx = 12'd38;
    bally = 12'd28;
    repeat (2 * FS * 2 + 40) @(negedge clk);

    // far off-screen; must not wrap onto the visible area
    ballx = 12'd4094;
    bally = 12'd4094;
    repeat (3 * FS) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
